mem_bus_arbiter: RTL

Shares the single CPU system-bus master port between two LSU-style requesters: the instruction-fetch port (I) and the memory-access-stage data port (D).
- Each requester issues a one-cycle command pulse and then waits on a busy level.
- The arbiter captures the command, serialises it onto the bus (one outstanding transaction at a time) and returns read data and bus errors to the requester that owns it.
- Sits between the pipeline stages and the bus interface unit.

---
 rtl/mem_bus_arbiter_pkg.sv | 5 +
 rtl/mem_bus_req_slot.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: LSU command/size encoding and arbiter FSM states
package mem_bus_arbiter_pkg;
    typedef enum logic [1:0] {LSU_IDLE = 2'd0, LSU_BYTE = 2'd1, LSU_HWORD = 2'd2, LSU_WORD = 2'd3} lsu_cmd_t;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;
endpackage

// File: rtl/mem_bus_req_slot.sv
// mem_bus_req_slot: one requester's pending command register with capture, clear-on-grant and busy
module mem_bus_req_slot
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [1:0]            cmd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rnw,
    input  logic                  owned,
    input  logic                  grant,
    output logic                  pending,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [1:0]            req_size,
    output logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_rnw
);
    logic capture;
    // a command while the port is already busy is a protocol violation and is dropped
    assign capture = cmd != LSU_IDLE && !pending && !owned;
    assign busy    = cmd != LSU_IDLE || pending || owned;
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            pending   <= 1'b0;
            req_addr  <= '0;
            req_size  <= '0;
            req_wdata <= '0;
            req_rnw   <= 1'b0;
        end else if (capture) begin
            pending   <= 1'b1;
            req_addr  <= addr;
            req_size  <= cmd;
            req_wdata <= wdata;
            req_rnw   <= rnw;
        end else if (grant)
            pending <= 1'b0;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises I/D LSU commands onto one bus master port; MEM_BUS_ARB_RR_EN selects round-robin
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [1:0]            i_cmd,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_busy,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_err,
    input  logic [1:0]            d_cmd,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_rnw,
    output logic                  d_busy,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  o_bus_req,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [1:0]            o_bus_size,
    output logic                  o_bus_rnw,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    input  logic                  i_bus_ack,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    input  logic                  i_bus_err
);
    state_t                state;
    logic                  i_pend, d_pend, grant_i, grant_d, i_rnw_q, d_rnw_q;
    logic [ADDR_WIDTH-1:0] i_addr_q, d_addr_q;
    logic [DATA_WIDTH-1:0] i_wdata_q, d_wdata_q;
    logic [1:0]            i_size_q, d_size_q;
`ifdef MEM_BUS_ARB_RR_EN
    logic                  last_d;
    assign grant_d = state == IDLE && d_pend && (!i_pend || !last_d);
`else
    assign grant_d = state == IDLE && d_pend;
`endif
    assign grant_i = state == IDLE && i_pend && !grant_d;

    mem_bus_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot_i (
        .clk(clk), .nrst(nrst), .cmd(i_cmd), .addr(i_addr), .wdata('0), .rnw(1'b1),
        .owned(state == BUSY_I), .grant(grant_i), .pending(i_pend), .busy(i_busy),
        .req_addr(i_addr_q), .req_size(i_size_q), .req_wdata(i_wdata_q), .req_rnw(i_rnw_q)
    );

    mem_bus_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot_d (
        .clk(clk), .nrst(nrst), .cmd(d_cmd), .addr(d_addr), .wdata(d_wdata), .rnw(d_rnw),
        .owned(state == BUSY_D), .grant(grant_d), .pending(d_pend), .busy(d_busy),
        .req_addr(d_addr_q), .req_size(d_size_q), .req_wdata(d_wdata_q), .req_rnw(d_rnw_q)
    );

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state       <= IDLE;
            o_bus_req   <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_size  <= '0;
            o_bus_rnw   <= 1'b0;
            o_bus_wdata <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            i_err       <= 1'b0;
            d_err       <= 1'b0;
`ifdef MEM_BUS_ARB_RR_EN
            last_d      <= 1'b0;
`endif
        end else begin
            i_err <= 1'b0;
            d_err <= 1'b0;
            if (grant_i || grant_d) begin
                state       <= grant_d ? BUSY_D : BUSY_I;
                o_bus_req   <= 1'b1;
                o_bus_addr  <= grant_d ? d_addr_q : i_addr_q;
                o_bus_size  <= grant_d ? d_size_q : i_size_q;
                o_bus_rnw   <= grant_d ? d_rnw_q : i_rnw_q;
                o_bus_wdata <= grant_d ? d_wdata_q : i_wdata_q;
`ifdef MEM_BUS_ARB_RR_EN
                last_d      <= grant_d;
`endif
            end else if (state != IDLE && i_bus_ack) begin
                state     <= IDLE;
                o_bus_req <= 1'b0;
                // erroring reads leave the requester's last good data in place
                if (state == BUSY_D) begin
                    d_err <= i_bus_err;
                    if (o_bus_rnw && !i_bus_err) d_rdata <= i_bus_rdata;
                end else begin
                    i_err <= i_bus_err;
                    if (o_bus_rnw && !i_bus_err) i_rdata <= i_bus_rdata;
                end
            end
        end
endmodule
